// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: it synchronizes and filters the line, frames 11-bit bytes,
// and strips the E0/F0 prefixes into key events with an auto-repeat-free Enter strobe.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_extended,
    output logic       enter_pulse,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic        filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [10:0] shift_q, shift_d;
    logic        ext_q, ext_d, brk_q, brk_d, held_q, held_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_break_q, key_break_d;
    logic        key_ext_q, key_ext_d;
    logic        enter_q, enter_d;
    logic        ferr_q, ferr_d;
    logic        flip, fall, frame_ok;
    logic [7:0]  rx_byte;

    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // The filtered clock follows the synchronized one only after FILTER_LEN
        // consecutive disagreeing samples, so short glitches never reach the FSM.
        flip       = 1'b0;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flip   = 1'b1;
                filt_d = ~filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall = flip & filt_q;

        tmo_d = flip ? '0 : ((tmo_q >= TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1));

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        enter_d     = 1'b0;
        ferr_d      = 1'b0;
        frame_ok    = 1'b0;
        rx_byte     = shift_d[8:1];

        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    shift_d   = {dat_s2_q, shift_q[10:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d  = IDLE;
                        rx_byte  = shift_d[8:1];
                        frame_ok = ~shift_d[0] & shift_d[10] & (^shift_d[9:1]);
                        if (!frame_ok) begin
                            ferr_d = 1'b1;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end else if (rx_byte == CODE_EXT) begin
                            ext_d = 1'b1;
                        end else if (rx_byte == CODE_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            key_valid_d = 1'b1;
                            key_code_d  = rx_byte;
                            key_break_d = brk_q;
                            key_ext_d   = ext_q;
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                            // Typematic repeats of a held Enter keep key_valid but not enter_pulse.
                            if (rx_byte == CODE_ENTER) begin
                                enter_d = ~brk_q & ~held_q;
                                held_d  = ~brk_q;
                            end
                        end
                    end
                end else if (tmo_q >= TW'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            tmo_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            enter_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_q       <= tmo_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            enter_q     <= enter_d;
            ferr_q      <= ferr_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_break    = key_break_q;
    assign key_extended = key_ext_q;
    assign enter_pulse  = enter_q;
    assign frame_err    = ferr_q;
endmodule
